if2_stage: RTL and testbench



---
 rtl/if2_stage_pkg.sv | 51 +++++
 rtl/if2_stage_inst_hold_buf.sv | 70 +++++++
 rtl/if2_stage.sv | 77 +++++++
 tb/tb_if2_stage.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/if2_stage_pkg.sv
// Shared definitions for the second instruction-fetch stage: bus widths,
// stall-vector bit positions, bus layouts and the hold-buffer state encoding.
package if2_stage_pkg;

  // Global stall vector width and the bit owned by each pipeline stage.
  localparam int STALL_W    = 6;
  localparam int STALL_IF1  = 0;
  localparam int STALL_IF2  = 1;
  localparam int STALL_ID   = 2;

  // Inter-stage bus widths.
  localparam int IF12IF2_WD = 33;
  localparam int IF22ID_WD  = 64;

  // IF1 -> IF2 handover: {valid, pc}.
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
  } if12if2_t;

  // IF2 -> ID handover: {pc, inst}.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } if22id_t;

  // Instruction hold buffer: PASS forwards live SRAM data, HOLD replays the
  // word captured when IF2 became stalled.
  typedef enum logic {
    BUF_PASS = 1'b0,
    BUF_HOLD = 1'b1
  } buf_state_e;

  // Build the ID-side bus, substituting the bubble pattern for invalid slots.
  function automatic if22id_t make_if22id(input logic        valid,
                                          input logic [31:0] pc,
                                          input logic [31:0] inst,
                                          input logic [31:0] bubble_pc,
                                          input logic [31:0] bubble_inst);
    if22id_t bus;
    if (valid) begin
      bus.pc   = pc;
      bus.inst = inst;
    end else begin
      bus.pc   = bubble_pc;
      bus.inst = bubble_inst;
    end
    return bus;
  endfunction

endpackage

// File: rtl/if2_stage_inst_hold_buf.sv
// Instruction hold buffer for IF2. The instruction SRAM only returns data in
// the cycle right after IF1 issues an address; if IF2 is stalled in that
// cycle the word is captured here and replayed until the stall releases.
module inst_hold_buf
  import if2_stage_pkg::*;
#(
  parameter logic [31:0] BUBBLE_PC   = 32'h0000_0000,
  parameter logic [31:0] BUBBLE_INST = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall_if2,
  input  logic                 br_e,
  input  logic                 fresh,
  input  logic [31:0]          inst_sram_rdata,
  input  logic                 valid,
  input  logic [31:0]          pc,
  output logic [IF22ID_WD-1:0] if22id_bus
);

  buf_state_e  buf_state;
  logic [31:0] inst_buf;
  logic [31:0] inst_cur;
  if22id_t     bus;

  // PASS/HOLD state and capture register for the stalled instruction word.
  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  // NOTE: inst_buf is a single data register, not an array, so it is reset
  // along with the state; a reset bubble never exposes stale SRAM data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_state <= BUF_PASS;
      inst_buf  <= '0;
    end else begin
      unique case (buf_state)
        BUF_PASS: begin
          // Only the fresh cycle carries the word belonging to pc; a branch
          // kills the slot, so there is nothing worth keeping.
          if (stall_if2 && fresh && !br_e) begin
            buf_state <= BUF_HOLD;
            inst_buf  <= inst_sram_rdata;
          end
        end
        BUF_HOLD: begin
          // Leave HOLD once IF2 advances or the slot is flushed; the stale
          // contents of inst_buf are never selected again from PASS.
          if (!stall_if2 || br_e) begin
            buf_state <= BUF_PASS;
          end
        end
        default: buf_state <= BUF_PASS;
      endcase
    end
  end

  // Select the instruction presented to ID and apply the bubble pattern.
  // NOTE: every combinational output gets a value on every path (default
  // first) so no latch is inferred.
  always_comb begin
    inst_cur = inst_sram_rdata;
    if (buf_state == BUF_HOLD) begin
      inst_cur = inst_buf;
    end
    bus = make_if22id(valid, pc, inst_cur, BUBBLE_PC, BUBBLE_INST);
  end

  assign if22id_bus = bus;

endmodule

// File: rtl/if2_stage.sv
// Second fetch stage. Registers the PC handed over by IF1, pairs it with the
// synchronous instruction-SRAM read data and presents {pc, inst} to ID,
// inserting bubbles on branch flush and when IF1 is held while IF2 drains.
module if2_stage
  import if2_stage_pkg::*;
#(
  parameter logic [31:0] BUBBLE_PC   = 32'h0000_0000,
  parameter logic [31:0] BUBBLE_INST = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [STALL_W-1:0]    stall,
  input  logic                  br_e,
  input  logic [IF12IF2_WD-1:0] if12if2_bus,
  input  logic [31:0]           inst_sram_rdata,
  output logic [IF22ID_WD-1:0]  if22id_bus
);

  if12if2_t if1_in;
  logic     valid_r;
  logic [31:0] pc_r;
  logic     fresh_r;
  logic     stall_if1;
  logic     stall_if2;
  logic     load_en;

  // ID's own stall and the upper bits are consumed by later stages only.
  logic unused_stall;
  assign unused_stall = ^stall[STALL_W-1:STALL_ID];

  assign if1_in    = if12if2_t'(if12if2_bus);
  assign stall_if1 = stall[STALL_IF1];
  assign stall_if2 = stall[STALL_IF2];

  // A new PC is taken only when nothing flushes the slot, IF1 is not held
  // and IF2 itself is free to advance.
  assign load_en = !br_e && !stall_if1 && !stall_if2;

  // Stage register: flush, drain-bubble, load, hold in priority order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= 1'b0;
      pc_r    <= '0;
      fresh_r <= 1'b0;
    end else begin
      if (br_e) begin
        valid_r <= 1'b0;
        pc_r    <= '0;
      end else if (stall_if1 && !stall_if2) begin
        // IF1 is held so it issued nothing new; IF2 drains into a bubble.
        valid_r <= 1'b0;
        pc_r    <= '0;
      end else if (!stall_if2) begin
        valid_r <= if1_in.valid;
        pc_r    <= if1_in.pc;
      end
      // SRAM data belongs to pc_r only in the cycle right after the load.
      fresh_r <= load_en && if1_in.valid;
    end
  end

  inst_hold_buf #(
    .BUBBLE_PC   (BUBBLE_PC),
    .BUBBLE_INST (BUBBLE_INST)
  ) u_inst_hold_buf (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall_if2       (stall_if2),
    .br_e            (br_e),
    .fresh           (fresh_r),
    .inst_sram_rdata (inst_sram_rdata),
    .valid           (valid_r),
    .pc              (pc_r),
    .if22id_bus      (if22id_bus)
  );

endmodule

// File: tb/tb_if2_stage.sv
// Self-checking bench for if2_stage. Each cycle the stimulus is driven just
// after the rising edge, the expected if22id_bus for that cycle is pushed to
// a scoreboard queue, and the DUT output is popped/compared at the falling edge.
module tb_if2_stage;
  import if2_stage_pkg::*;

  localparam logic [5:0] S_NONE = 6'b000000;
  localparam logic [5:0] S_IF1  = 6'b000001;
  localparam logic [5:0] S_IF2  = 6'b000110;
  localparam logic [5:0] S_ID   = 6'b000100;

  logic                  clk;
  logic                  rst_n;
  logic [STALL_W-1:0]    stall;
  logic                  br_e;
  logic [IF12IF2_WD-1:0] if12if2_bus;
  logic [31:0]           inst_sram_rdata;
  logic [IF22ID_WD-1:0]  if22id_bus;

  typedef struct {
    string       tag;
    logic [63:0] exp;
  } sb_entry_t;

  sb_entry_t sb_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  if2_stage dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall           (stall),
    .br_e            (br_e),
    .if12if2_bus     (if12if2_bus),
    .inst_sram_rdata (inst_sram_rdata),
    .if22id_bus      (if22id_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Pop the oldest expectation and compare it against the live output.
  task automatic sb_compare();
    sb_entry_t e;
    if (sb_q.size() == 0) begin
      check("sb_underflow", if22id_bus, 64'hx);
    end else begin
      e = sb_q.pop_front();
      check(e.tag, if22id_bus, e.exp);
    end
  endtask

  // One clock cycle: drive inputs, record the expected output, sample it
  // mid-cycle, then advance to just after the next rising edge.
  task automatic cycle(input string tag, input logic [5:0] st, input logic br,
                       input logic v, input logic [31:0] pc,
                       input logic [31:0] rdata, input logic [63:0] exp);
    sb_entry_t e;
    stall           = st;
    br_e            = br;
    if12if2_bus     = {v, pc};
    inst_sram_rdata = rdata;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
    @(negedge clk);
    sb_compare();
    @(posedge clk);
    #1;
  endtask

  initial begin
    sb_entry_t e;
    rst_n           = 1'b0;
    stall           = S_NONE;
    br_e            = 1'b0;
    if12if2_bus     = {1'b1, 32'h8000_0000};
    inst_sram_rdata = 32'hFFFF_FFFF;

    // Reset: output is a bubble even with live-looking inputs.
    @(negedge clk);
    check("reset_bubble", if22id_bus, 64'h0);
    @(posedge clk);
    #1;
    check("reset_bubble_after_edge", if22id_bus, 64'h0);
    rst_n = 1'b1;

    // Straight-line flow, one instruction per cycle.
    cycle("line_first_bubble", S_NONE, 0, 1, 32'h8000_0000, 32'h0000_0000, 64'h0);
    cycle("line_pc0",  S_NONE, 0, 1, 32'h8000_0004, 32'h0000_0093, 64'h8000_0000_0000_0093);
    cycle("line_pc4",  S_NONE, 0, 1, 32'h8000_0008, 32'h0010_0113, 64'h8000_0004_0010_0113);
    cycle("line_pc8",  S_NONE, 0, 0, 32'h0000_0000, 32'h0020_0193, 64'h8000_0008_0020_0193);
    cycle("invalid_bubble", S_NONE, 0, 1, 32'h8000_0010, 32'h1234_5678, 64'h0);

    // Stall hold: captured word replayed while SRAM data changes.
    cycle("stall_fresh", S_IF2, 0, 1, 32'h8000_0014, 32'h00A0_0513, 64'h8000_0010_00A0_0513);
    cycle("stall_hold1", S_IF2, 0, 1, 32'h8000_0014, 32'hDEAD_BEEF, 64'h8000_0010_00A0_0513);
    cycle("stall_hold2", S_IF2, 0, 1, 32'h8000_0014, 32'hDEAD_BEEF, 64'h8000_0010_00A0_0513);
    cycle("stall_release", S_NONE, 0, 1, 32'h8000_0014, 32'hDEAD_BEEF, 64'h8000_0010_00A0_0513);
    cycle("after_release", S_NONE, 0, 1, 32'h8000_0020, 32'h00B0_0593, 64'h8000_0014_00B0_0593);

    // Branch flush while HOLD: buffered word dropped, next PC passes live.
    cycle("flush_fresh", S_IF2, 0, 1, 32'h8000_0024, 32'h00C0_0613, 64'h8000_0020_00C0_0613);
    cycle("flush_in_hold", S_IF2, 1, 1, 32'h8000_0024, 32'hDEAD_BEEF, 64'h8000_0020_00C0_0613);
    cycle("flush_bubble", S_NONE, 0, 1, 32'h8000_0100, 32'hCAFE_F00D, 64'h0);
    cycle("flush_next_pc", S_NONE, 0, 0, 32'h0000_0000, 32'h00D0_0693, 64'h8000_0100_00D0_0693);

    // IF1-only stall: two drain bubbles, then normal flow.
    cycle("if1_pre", S_NONE, 0, 1, 32'h8000_0200, 32'h1111_1111, 64'h0);
    cycle("if1_stall_a", S_IF1, 0, 1, 32'h8000_0204, 32'h00E0_0713, 64'h8000_0200_00E0_0713);
    cycle("if1_bubble1", S_IF1, 0, 1, 32'h8000_0204, 32'h2222_2222, 64'h0);
    cycle("if1_bubble2", S_NONE, 0, 1, 32'h8000_0204, 32'h3333_3333, 64'h0);
    cycle("if1_resume", S_ID, 0, 0, 32'h0000_0000, 32'h00F0_0793, 64'h8000_0204_00F0_0793);

    // br_e with IF1-only stall and a valid incoming PC: nothing is loaded.
    cycle("br_if1_pre", S_IF1, 1, 1, 32'h8000_0300, 32'h4444_4444, 64'h0);
    cycle("br_if1_noload", S_NONE, 1, 1, 32'h8000_0304, 32'h5555_5555, 64'h0);
    cycle("br_only_noload", S_NONE, 0, 0, 32'h0000_0000, 32'h6666_6666, 64'h0);

    // Async reset in HOLD: bubble before the next edge, clean restart.
    cycle("rst_pre", S_NONE, 0, 1, 32'h8000_0400, 32'h0000_0000, 64'h0);
    cycle("rst_fresh", S_IF2, 0, 1, 32'h8000_0404, 32'h0100_0813, 64'h8000_0400_0100_0813);
    stall           = S_IF2;
    inst_sram_rdata = 32'hDEAD_BEEF;
    e.tag = "rst_hold";
    e.exp = 64'h8000_0400_0100_0813;
    sb_q.push_back(e);
    @(negedge clk);
    sb_compare();
    #2;
    rst_n = 1'b0;
    e.tag = "rst_async_bubble";
    e.exp = 64'h0;
    sb_q.push_back(e);
    #1;
    sb_compare();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle("rst_restart_bubble", S_NONE, 0, 1, 32'h8000_0000, 32'hDEAD_BEEF, 64'h0);
    cycle("rst_restart_pc0", S_NONE, 0, 0, 32'h0000_0000, 32'h0000_0093, 64'h8000_0000_0000_0093);

    check("sb_drained", 64'(sb_q.size()), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
